// File: rtl/uart_tx_unit_pkg.sv
// Shared MiniUart transmit definitions: FSM state encodings, timing default, parity helper.
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
package uart_tx_unit_pkg;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t StIdle   = 3'd0;
  localparam tx_state_t StStart  = 3'd1;
  localparam tx_state_t StData   = 3'd2;
  localparam tx_state_t StParity = 3'd3;
  localparam tx_state_t StStop   = 3'd4;

  localparam int unsigned ClksPerBitDefault = 8;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// CPU-side and line-side signal bundle of the MiniUart transmit unit.
interface uart_tx_unit_if;
  logic       en_tx;
  logic [7:0] d_in;
  logic       load;
  logic       ts;
  logic       busy;
  logic       txd;

  modport master (output en_tx, d_in, load, input ts, busy, txd);
  modport slave  (input en_tx, d_in, load, output ts, busy, txd);
endinterface

// File: rtl/uart_tx_unit_shift.sv
// Transmit shift register, LSB first; with UART_TX_PARITY_EN it also latches the
// even parity of the loaded byte.
module uart_tx_unit_shift
  import uart_tx_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  output logic       bit_o,
`ifdef UART_TX_PARITY_EN
  output logic       parity_o,
`endif
  output logic       next_bit_o
);

  logic [7:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (shift_i) begin
      shift_d = {1'b0, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= 8'h00;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bit_o      = shift_q[0];
  assign next_bit_o = shift_q[1];

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (load_i) begin
      parity_d = even_parity(data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: rtl/uart_tx_unit.sv
// MiniUart transmit unit: one-byte holding register feeding an 8N1 serialiser timed by en_tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_tx_unit
  import uart_tx_unit_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic           clk,
  input logic           rst,
  uart_tx_unit_if.slave bus
);

  localparam logic [3:0] TickMax = 4'(CLKS_PER_BIT - 1);
  localparam logic [2:0] StopMax = 3'(STOP_BITS - 1);

  tx_state_t  state_q, state_d;
  logic [3:0] cnt_tick_q, cnt_tick_d;
  logic [2:0] cnt_bits_q, cnt_bits_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic       txd_q, txd_d;
  logic       sh_load, sh_shift, sh_bit, sh_next;
  logic       bit_end;
`ifdef UART_TX_PARITY_EN
  logic       sh_par;
`endif

  assign bit_end = bus.en_tx && (cnt_tick_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    cnt_tick_d = cnt_tick_q;
    cnt_bits_d = cnt_bits_q;
    txd_d      = txd_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    if (bus.en_tx) begin
      if (state_q inside {StStart, StData, StParity, StStop}) begin
        cnt_tick_d = (cnt_tick_q == 4'd0) ? TickMax : cnt_tick_q - 4'd1;
      end
      case (state_q)
        StIdle: begin
          if (thr_full_q) begin
            sh_load    = 1'b1;
            txd_d      = 1'b0;
            cnt_tick_d = TickMax;
            cnt_bits_d = 3'd7;
            state_d    = StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            txd_d   = sh_bit;
            state_d = StData;
          end
        end
        StData: begin
          if (bit_end) begin
            sh_shift = 1'b1;
            if (cnt_bits_q != 3'd0) begin
              cnt_bits_d = cnt_bits_q - 3'd1;
              txd_d      = sh_next;
            end else begin
`ifdef UART_TX_PARITY_EN
              txd_d   = sh_par;
              state_d = StParity;
`else
              txd_d      = 1'b1;
              cnt_bits_d = StopMax;
              state_d    = StStop;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            txd_d      = 1'b1;
            cnt_bits_d = StopMax;
            state_d    = StStop;
          end
        end
`endif
        StStop: begin
          // cnt_bits counts remaining stop bits; a queued byte starts with no idle tick
          if (bit_end) begin
            if (cnt_bits_q != 3'd0) begin
              cnt_bits_d = cnt_bits_q - 3'd1;
            end else if (thr_full_q) begin
              sh_load    = 1'b1;
              txd_d      = 1'b0;
              cnt_bits_d = 3'd7;
              state_d    = StStart;
            end else begin
              txd_d   = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    if (sh_load) begin
      thr_full_d = 1'b0;
    end else if (bus.load && !thr_full_q) begin
      thr_d      = bus.d_in;
      thr_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_tick_q <= 4'd0;
      cnt_bits_q <= 3'd0;
      thr_q      <= 8'h00;
      thr_full_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_tick_q <= cnt_tick_d;
      cnt_bits_q <= cnt_bits_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      txd_q      <= txd_d;
    end
  end

  uart_tx_unit_shift u_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (sh_load),
    .shift_i    (sh_shift),
    .data_i     (thr_q),
    .bit_o      (sh_bit),
`ifdef UART_TX_PARITY_EN
    .parity_o   (sh_par),
`endif
    .next_bit_o (sh_next)
  );

  assign bus.ts   = ~thr_full_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.txd  = txd_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: line levels compared against a per-bit frame model.
module tb_uart_tx_unit;

  localparam int unsigned Cpb      = 8;
  localparam int unsigned StopBits = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned ParBits  = 1;
`else
  localparam int unsigned ParBits  = 0;
`endif

  logic clk;
  logic rst;

  uart_tx_unit_if bus ();

  uart_tx_unit #(
    .CLKS_PER_BIT (Cpb),
    .STOP_BITS    (StopBits)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_fail;
  int   gap;
  int   phase;
  logic obs_txd[$];
  logic obs_busy[$];
  logic obs_ts[$];
  logic exp_bits[$];  // expected line level for each successive bit period

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample outputs 1 time unit later.
  task automatic cyc(input logic do_load, input logic [7:0] b);
    bus.load  = do_load;
    bus.d_in  = b;
    bus.en_tx = (phase == 0);
    phase     = (phase + 1) % gap;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    obs_txd.push_back(bus.txd);
    obs_busy.push_back(bus.busy);
    obs_ts.push_back(bus.ts);
  endtask

  task automatic add_frame(input logic [7:0] b);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (ParBits != 0) exp_bits.push_back(logic'($countones(b) % 2));
    for (int i = 0; i < StopBits; i++) exp_bits.push_back(1'b1);
  endtask

  // Load a byte so that the first en_tx strobe lands on the following edge.
  task automatic start_frame(input logic [7:0] b, input int g);
    gap   = g;
    phase = g - 1;
    cyc(1'b1, b);
    check("ts after load", obs_ts[$], 1'b0);
    obs_txd.delete();
    obs_busy.delete();
    obs_ts.delete();
    exp_bits.delete();
    add_frame(b);
  endtask

  task automatic finish_check(input string tag);
    int   len;
    int   total;
    int   blen;
    logic seen;
    len   = Cpb * gap;
    total = exp_bits.size() * len;
    while (obs_txd.size() < total + 2 * len) cyc(1'b0, 8'h00);
    for (int k = 0; k < exp_bits.size(); k++) begin
      seen = obs_txd[k * len];
      for (int j = k * len; j < (k + 1) * len; j++) begin
        if (obs_txd[j] !== exp_bits[k]) seen = obs_txd[j];
      end
      check($sformatf("%s bit%0d", tag, k), seen, exp_bits[k]);
    end
    seen = obs_txd[total];
    for (int j = total; j < total + 2 * len; j++) begin
      if (obs_txd[j] !== 1'b1) seen = obs_txd[j];
    end
    check($sformatf("%s idle", tag), seen, 1'b1);
    blen = 0;
    while (blen < obs_busy.size() && obs_busy[blen] === 1'b1) blen++;
    check($sformatf("%s busy cycles", tag), blen, total);
    check($sformatf("%s ts after transfer", tag), obs_ts[0], 1'b1);
  endtask

  initial begin
    logic [7:0] r;
    int         g;
    int         base;
    logic       seen_txd;
    logic       seen_busy;

    n_chk     = 0;
    n_fail    = 0;
    gap       = 1;
    phase     = 0;
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.d_in  = 8'h00;
    bus.en_tx = 1'b0;
    repeat (3) cyc(1'b0, 8'h00);
    rst = 1'b0;
    check("reset txd", obs_txd[$], 1'b1);
    check("reset ts", obs_ts[$], 1'b1);
    check("reset busy", obs_busy[$], 1'b0);

    start_frame(8'h55, 1);
    finish_check("single55");

    start_frame(8'hA5, 1);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h3C);
    add_frame(8'h3C);
    finish_check("b2b");

    r = 8'($urandom);
    start_frame(r, 1);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h11);
    check("overrun ts full", obs_ts[$], 1'b0);
    cyc(1'b1, 8'h22);
    add_frame(8'h11);
    finish_check("overrun");

    r = 8'($urandom);
    start_frame(r, 4);
    finish_check("gap4");

    for (int t = 0; t < 4; t++) begin
      r = 8'($urandom);
      g = int'($urandom_range(1, 3));
      start_frame(r, g);
      finish_check($sformatf("rnd%0d", t));
    end

    start_frame(8'h07, 1);
    finish_check("x07");
    start_frame(8'h03, 1);
    finish_check("x03");

    // Abort in data bit 3 with a second byte queued; both must vanish.
    r = 8'($urandom);
    start_frame(r, 1);
    cyc(1'b0, 8'h00);
    cyc(1'b1, ~r);
    while (obs_txd.size() < 36) cyc(1'b0, 8'h00);
    check("pre-reset data bit3", obs_txd[35], r[3]);
    rst = 1'b1;
    cyc(1'b0, 8'h00);
    rst = 1'b0;
    check("midreset txd", obs_txd[$], 1'b1);
    check("midreset ts", obs_ts[$], 1'b1);
    check("midreset busy", obs_busy[$], 1'b0);
    base = obs_txd.size();
    repeat (3 * Cpb) cyc(1'b0, 8'h00);
    seen_txd  = obs_txd[base];
    seen_busy = obs_busy[base];
    for (int j = base; j < obs_txd.size(); j++) begin
      if (obs_txd[j] !== 1'b1) seen_txd = obs_txd[j];
      if (obs_busy[j] !== 1'b0) seen_busy = obs_busy[j];
    end
    check("held byte discarded txd", seen_txd, 1'b1);
    check("held byte discarded busy", seen_busy, 1'b0);
    start_frame(8'hFF, 1);
    finish_check("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
# uart_tx_unit

Transmitting unit of MiniUart, the counterpart of the receiving unit. It accepts a byte from the CPU-side bus interface into a one-byte holding register and shifts it out serially on TxD as an 8N1 frame (start bit, 8 data bits LSB first, stop bit). Bit timing is driven by the same 8x-baud enable strobe that the receiver uses. The holding register lets the CPU queue the next byte while the current frame is on the line, so back-to-back frames have no idle gap.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 8: number of `en_tx` strobes per bit period. It matches the receiver's 8x oversampling. Legal range is 2..16.
- `STOP_BITS`, default 1: number of stop bits, either 1 or 2.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `en_tx`, input, 1: baud-tick enable, one `clk` cycle wide, at `CLKS_PER_BIT` times the baud rate.
- `d_in`, input, 8: byte to transmit.
- `load`, input, 1: CPU write strobe to the transmit data register.
- `ts`, output, 1: transmit status. 1 means the holding register is empty and will accept a byte.
- `busy`, output, 1: a frame is on the line (FSM is not IDLE).
- `txd`, output, 1: serial output, registered, idles high.

## Operation
- Holding register (`thr`, 8 bits) and full flag (`thr_full`). `ts` = `!thr_full`.
- A `load` with `ts`=1 captures `d_in` into `thr` and sets `thr_full`. A `load` with `ts`=0 is ignored; the byte is dropped and `thr` is unchanged.
- The FSM and the tick counter (`cnt_tick`, 4 bits) and bit counter (`cnt_bits`, 3 bits) advance only in cycles where `en_tx`=1. `load` and `ts` are independent of `en_tx`.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE, with `en_tx` and `thr_full`: copy `thr` to the shift register, clear `thr_full`, set `txd`=0, set `cnt_tick`=`CLKS_PER_BIT`-1 and `cnt_bits`=7, then go to START.
  - START, DATA, PARITY and STOP: decrement `cnt_tick` on each `en_tx`. When `cnt_tick`==0 and `en_tx`=1, the bit period ends: reload `cnt_tick` and drive the next bit.
  - START ends, then DATA begins with `txd`=shift[0].
  - DATA: at the end of each bit, shift right. When `cnt_bits`==0, go to PARITY if it is compiled in, otherwise to STOP. In both cases `txd`=1 except in PARITY, where `txd`=parity.
  - STOP lasts `STOP_BITS`×`CLKS_PER_BIT` ticks. At the end, if `thr_full`, load the next byte and go directly to START with `txd`=0, leaving no idle tick. Otherwise go to IDLE with `txd`=1.
  - Undefined state: go to IDLE and set `txd`=1.
- Simultaneous events:
  - A `load` in the same cycle that `thr` is transferred sees `ts`=0 and is dropped.
  - A `load` during any frame state with `ts`=1 is accepted.
- Reset values: `txd`=1, `ts`=1, `busy`=0, FSM=IDLE, counters 0, `thr`=0. A reset mid-frame aborts the frame: `txd`=1 on the next edge and the held byte is discarded.

## Timing
- `load` sampled at edge N gives `ts`=0 after edge N.
- The first `en_tx` at edge M > N gives `txd`=0 and `busy`=1 after edge M. `ts` returns to 1 after edge M.
- Every bit lasts exactly `CLKS_PER_BIT` `en_tx` strobes, regardless of gaps between strobes.
- Frame length in strobes: (1+8+`STOP_BITS`)×`CLKS_PER_BIT`, plus `CLKS_PER_BIT` when parity is enabled.
- `busy` falls on the same edge on which `txd` completes the last stop bit and the FSM enters IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is present, and `txd` carries the even parity of the 8 data bits (XOR of all data bits) for one bit period between the last data bit and the stop bit(s).
- `UART_TX_PARITY_EN` undefined: no PARITY state, and STOP follows DATA directly.

## Structure
- The shared MiniUart header `head_uart.v` holds the FSM state encodings, the `CLKS_PER_BIT` default, and the `UART_TX_PARITY_EN` switch, alongside the existing `HALF_BIT`.
- One sub-module is natural: `uart_tx_shift`, the 8-bit shift register with parity accumulator, controlled by load and shift strobes.

## Test plan
- Single byte, default parameters, `en_tx`=1 every cycle: `load` 0x55 gives `txd` = 0,1,0,1,0,1,0,1,0,1, each level held for 8 cycles, then idle high. `busy` stays high for 80 cycles.
- Back-to-back: `load` 0xA5, then `load` 0x3C once `ts`=1. The stop bit of 0xA5 is followed immediately by the start bit of 0x3C with no idle cycle, and the received bits match LSB first.
- Overrun: two `load`s, 0x11 then 0x22, while `ts`=0. Only 0x11 and the byte held before it are sent; 0x22 never appears.
- Gapped ticks: `en_tx` every 4th cycle gives 32 `clk` cycles per bit and an unchanged bit sequence.
- Reset mid-frame during DATA bit 3: `txd`=1, `ts`=1 and `busy`=0 one edge later. A following `load` 0xFF transmits cleanly.
- With `UART_TX_PARITY_EN`: 0x07 gives a parity bit of 1, and 0x03 gives a parity bit of 0. The frame is 88 cycles with `en_tx`=1 every cycle.
